// File: rtl/data_field.sv
// ----------------------------------------------------------------------------
// data_field
//   Serialises the data field of a frame: up to 8 payload bytes, byte 0
//   (data[63:56]) first, MSB first. One bit advances on each rising edge of
//   the bit-timing strobe sample_point.
//
// Ports
//   clock            in   rising-edge clock
//   reset_n          in   synchronous reset, active-high despite the name
//   enable           in   block enable; 0 aborts and holds idle
//   sample_point     in   bit-timing strobe; each 0->1 advances one bit
//   Tx_request       in   transmit request from the frame controller
//   control_complete in   control field finished; data field may start
//   dlc    [3:0]     in   data length code in bytes (9..15 treated as 8)
//   data   [63:0]    in   payload, latched at start
//   data_bit         out  serial bit; 1 (recessive) when not transmitting
//   bit_counter [5:0] out index of the bit currently on data_bit
//   data_complete    out  high while in COMPLETE
// ----------------------------------------------------------------------------
module data_field (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        sample_point,
    input  logic        Tx_request,
    input  logic        control_complete,
    input  logic [3:0]  dlc,
    input  logic [63:0] data,
    output logic        data_bit,
    output logic [5:0]  bit_counter,
    output logic        data_complete
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRANSMIT,
        S_COMPLETE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_sp_prev;
    logic [63:0] r_shift;
    logic [6:0]  r_nb;
    logic [5:0]  r_cnt;

    logic        w_advance;
    logic        w_start;
    logic        w_last;
    logic [3:0]  w_dlc_eff;

    assign w_dlc_eff = (dlc > 4'd8) ? 4'd8 : dlc;
    assign w_advance = sample_point & ~r_sp_prev;
    assign w_start   = enable & Tx_request & control_complete;
    assign w_last    = ({1'b0, r_cnt} == (r_nb - 7'd1));

    // State register
    always_ff @(posedge clock) begin
        if (reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; enable=0 overrides every other transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = (w_dlc_eff == 4'd0) ? S_COMPLETE : S_TRANSMIT;
                end
            end
            S_TRANSMIT: begin
                if (w_advance && w_last) begin
                    w_state_next = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                if (!Tx_request || !control_complete) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (!enable) begin
            w_state_next = S_IDLE;
        end
    end

    // Datapath: strobe history, payload shift register, bit total, bit index
    always_ff @(posedge clock) begin
        if (reset_n) begin
            r_sp_prev <= 1'b0;
            r_shift   <= '0;
            r_nb      <= '0;
            r_cnt     <= '0;
        end else begin
            r_sp_prev <= sample_point;
            if (r_state == S_IDLE && w_start) begin
                r_shift <= data;
                r_nb    <= {w_dlc_eff, 3'b000};
            end
            if (w_state_next == S_IDLE) begin
                r_cnt <= '0;
            end else if (r_state == S_TRANSMIT && w_advance && !w_last) begin
                r_cnt   <= r_cnt + 6'd1;
                r_shift <= {r_shift[62:0], 1'b0};
            end
        end
    end

    // Outputs: the current bit is always the MSB of the shift register
    always_comb begin
        data_bit      = 1'b1;
        data_complete = 1'b0;
        bit_counter   = r_cnt;
        case (r_state)
            S_TRANSMIT: data_bit = r_shift[63];
            S_COMPLETE: data_complete = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_field.sv
module tb_data_field;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        sample_point;
    logic        Tx_request;
    logic        control_complete;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        data_bit;
    logic [5:0]  bit_counter;
    logic        data_complete;

    int unsigned n_checks;
    int unsigned n_pass;

    // Reference model: expected serial bit sequence of the current frame
    bit          m_q[$];
    int unsigned m_nb;

    data_field dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .enable           (enable),
        .sample_point     (sample_point),
        .Tx_request       (Tx_request),
        .control_complete (control_complete),
        .dlc              (dlc),
        .data             (data),
        .data_bit         (data_bit),
        .bit_counter      (bit_counter),
        .data_complete    (data_complete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".data_bit"}, data_bit, 1);
        check_eq({tag, ".bit_counter"}, bit_counter, 0);
        check_eq({tag, ".data_complete"}, data_complete, 0);
    endtask

    task automatic check_complete(input string tag);
        check_eq({tag, ".data_complete"}, data_complete, 1);
        check_eq({tag, ".data_bit"}, data_bit, 1);
        check_eq({tag, ".bit_counter"}, bit_counter, (m_nb == 0) ? 0 : m_nb - 1);
    endtask

    task automatic check_bit(input int unsigned k);
        check_eq($sformatf("bit%0d.data_bit", k), data_bit, m_q[k]);
        check_eq($sformatf("bit%0d.bit_counter", k), bit_counter, k);
        check_eq($sformatf("bit%0d.data_complete", k), data_complete, 0);
    endtask

    task automatic start_frame(input logic [3:0] d, input logic [63:0] w);
        int unsigned n;
        n    = (d > 8) ? 8 : d;
        m_nb = 8 * n;
        m_q.delete();
        for (int unsigned k = 0; k < m_nb; k++) m_q.push_back(w[63-k]);
        sample_point     = 1'b0;
        enable           = 1'b1;
        Tx_request       = 1'b1;
        control_complete = 1'b1;
        dlc              = d;
        data             = w;
        tick();
    endtask

    // One strobe of random width and gap; payload inputs are scrambled
    // meanwhile since they must be ignored after start.
    task automatic strobe();
        int unsigned hi;
        int unsigned lo;
        hi   = $urandom_range(1, 3);
        lo   = $urandom_range(1, 2);
        dlc  = 4'($urandom);
        data = {$urandom, $urandom};
        sample_point = 1'b1;
        repeat (hi) tick();
        sample_point = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic send_bits(input int unsigned nbits);
        for (int unsigned k = 0; k < nbits; k++) begin
            check_bit(k);
            strobe();
        end
    endtask

    task automatic run_frame(input logic [3:0] d, input logic [63:0] w);
        start_frame(d, w);
        send_bits(m_nb);
        check_complete("done");
    endtask

    task automatic end_frame();
        repeat (2) tick();
        check_complete("hold");
        if ($urandom_range(0, 1) == 0) Tx_request = 1'b0;
        else control_complete = 1'b0;
        tick();
        check_idle("release");
        Tx_request       = 1'b0;
        control_complete = 1'b0;
        tick();
    endtask

    initial begin
        logic [63:0] w;
        n_checks         = 0;
        n_pass           = 0;
        m_nb             = 0;
        reset_n          = 1'b1;
        enable           = 1'b0;
        sample_point     = 1'b0;
        Tx_request       = 1'b0;
        control_complete = 1'b0;
        dlc              = '0;
        data             = '0;
        tick();
        tick();
        check_idle("reset");
        reset_n = 1'b0;
        tick();
        check_idle("post_reset");

        run_frame(4'd0,  64'h1122334455667788);
        end_frame();
        run_frame(4'd4,  64'hAABBCCDDEEFF0011);
        end_frame();
        run_frame(4'd8,  64'hDEADBEEFCAFEBABE);
        end_frame();
        run_frame(4'd12, 64'hDEADBEEFCAFEBABE);
        end_frame();
        run_frame(4'd2,  64'hFACEFACEFACEFACE);
        end_frame();

        // Abort after three bits, then restart from scratch
        start_frame(4'd4, 64'hAABBCCDDEEFF0011);
        send_bits(3);
        check_bit(3);
        enable = 1'b0;
        tick();
        check_idle("abort");
        run_frame(4'd4, 64'hAABBCCDDEEFF0011);
        end_frame();

        // Strobe held high for four clocks advances exactly one bit
        w = {$urandom, $urandom};
        start_frame(4'd8, w);
        check_bit(0);
        sample_point = 1'b1;
        repeat (4) tick();
        sample_point = 1'b0;
        tick();
        check_bit(1);
        strobe();
        check_bit(2);
        // Reset mid-frame
        reset_n          = 1'b1;
        Tx_request       = 1'b0;
        control_complete = 1'b0;
        tick();
        check_idle("mid_reset");
        reset_n = 1'b0;
        tick();
        check_idle("after_mid_reset");

        for (int unsigned i = 0; i < 8; i++) begin
            w = {$urandom, $urandom};
            run_frame(4'($urandom_range(0, 15)), w);
            end_frame();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_field.md
DATA_FIELD -- requirements
Module: data_field

Interface
REQ-001 Parameters: none; data width fixed at 64 bits, DLC width fixed at 4 bits.
REQ-002 clock  input  1  rising-edge clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  synchronous reset, active-high (asserted when 1, sampled on the rising clock edge; the port name is kept for codebase consistency).
REQ-004 enable  input  1  block enable; 0 aborts any activity and holds idle.
REQ-005 sample_point  input  1  bit-timing strobe; each rising edge (0->1 as sampled on clock) advances one data bit.
REQ-006 Tx_request  input  1  transmit request from frame controller.
REQ-007 control_complete  input  1  control field finished; data field may start.
REQ-008 dlc  input  4  data length code in bytes; values 9..15 treated as 8.
REQ-009 data  input  64  payload; data[63:56] = byte 0, transmitted first, MSB first.
REQ-010 data_bit  output  1  serial data bit; 1 (recessive) when not transmitting.
REQ-011 bit_counter  output  6  index of the bit currently driven on data_bit (0..63).
REQ-012 data_complete  output  1  high while in COMPLETE state.

Function
REQ-013 FSM states: IDLE, TRANSMIT, COMPLETE; encoding free.
REQ-014 Start condition: IDLE and enable=1 and Tx_request=1 and control_complete=1.
REQ-015 On start with effective DLC=0: next state COMPLETE (1 clock latency), no bits sent, bit_counter=0.
REQ-016 On start with effective DLC N>0: latch data into 64-bit shift register and latch bit total NB=8*N; enter TRANSMIT with bit_counter=0 and data_bit=data[63] on the same edge.
REQ-017 dlc and data changes after start are ignored until the next start.
REQ-018 sample_point edge detection: registered previous value; advance when sample_point=1 and previous=0; a strobe held high for several clocks advances only once.
REQ-019 In TRANSMIT on an advance: if bit_counter=NB-1, enter COMPLETE; else bit_counter+1, shift left one bit, data_bit = next bit.
REQ-020 Bit order: bit k (k=0..NB-1) on data_bit equals data[63-k].
REQ-021 In COMPLETE: data_complete=1, data_bit=1, bit_counter holds last value (NB-1, or 0 for DLC=0).
REQ-022 COMPLETE -> IDLE when Tx_request=0 or control_complete=0; otherwise hold COMPLETE (no retrigger while request stays high).
REQ-023 In IDLE: data_bit=1, data_complete=0, bit_counter=0.
REQ-024 enable=0 in any state: next state IDLE, outputs as REQ-023 on the next edge; partial transmission discarded; restart only through REQ-014.
REQ-025 enable=0 takes priority over sample_point advance and start condition; reset takes priority over all.
REQ-026 bit_counter never exceeds 63; no wrap occurs because NB-1 <= 63.

Reset
REQ-027 reset_n=1 at a rising edge: state IDLE, bit_counter=0, data_bit=1, data_complete=0, shift register and NB cleared, sample_point history cleared to 0.
REQ-028 Reset mid-TRANSMIT or COMPLETE behaves identically to REQ-027; no output glitch beyond the edge.

Verification
REQ-029 dlc=0, data=0x1122334455667788, enable=Tx_request=control_complete=1 -> data_complete=1 one clock after start, data_bit stays 1, bit_counter=0.
REQ-030 dlc=4, data=0xAABBCCDDEEFF0011, start -> 32 bits on data_bit equal 0xAABBCCDD MSB first, one per sample_point edge; data_complete rises on the 32nd advance with bit_counter=31.
REQ-031 dlc=8, data=0xDEADBEEFCAFEBABE -> 64 bits match full word MSB first; data_complete with bit_counter=63; dlc=12 gives identical result.
REQ-032 dlc=4 start, drop enable after 3 bits -> IDLE next edge, data_bit=1, bit_counter=0; re-enable with request high -> full 32-bit frame restarts from data[63].
REQ-033 dlc=2, data=0xFACEFACEFACEFACE -> bits 0xFACE, COMPLETE held while Tx_request=1; Tx_request=0 -> IDLE next edge, data_complete=0.
REQ-034 sample_point held high 4 clocks during TRANSMIT -> bit_counter advances by exactly 1; reset_n=1 mid-frame -> all outputs at reset values next edge.
